llink_tx_credit_fifo: RTL and testbench

//  Per-channel logic-link transmit buffer with credit-based flow control.
//  - Sits directly downstream of the AXI-MM packetizer.
//  - Accepts packed channel words (e.g. the 49b AR/AW or 149b W words) on a

---
 rtl/llink_tx_credit_fifo.sv | 174 +++++++++++++++++
 tb/tb_llink_tx_credit_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/llink_tx_credit_fifo.sv
// -----------------------------------------------------------------------------
// llink_tx_credit_fifo
//
// Per-channel logic-link transmit buffer with credit-based flow control.
// It sits downstream of the AXI-MM packetizer and accepts packed channel words
// on a valid/ready handshake, storing them in a FIFO. One word per cycle is
// popped toward the AIB transmit path. Pops happen only while the link is
// online (FSM in ACTIVE) and the far-side receiver has returned credits.
//
// Optional feature macro: LLINK_TX_STATUS_EN
//   defined     : status_level  = registered FIFO occupancy (0..DEPTH)
//                 status_credit = current credit count
//   not defined : both status ports are tied to 0 and no occupancy counter
//                 is built
//
// Ports
//   clk_wr            in   transmit-domain clock
//   rst_wr            in   asynchronous reset, active-high
//   tx_online         in   link trained and ready (level)
//   user_i_valid      in   upstream word valid
//   txfifo_i_data     in   upstream packed word [WIDTH]
//   user_i_ready      out  FIFO can accept a word (low while in reset)
//   tx_o_valid        out  one-cycle pushbit toward the link
//   tx_o_data         out  word accompanying tx_o_valid (holds when idle)
//   rx_credit_return  in   one-cycle pulse: far side freed one entry
//   credit_overflow   out  sticky: credit returned while counter at max
//   fifo_empty        out  FIFO holds no words
//   status_level      out  FIFO occupancy [ADDR_W+1]
//   status_credit     out  credit count [CRED_W]
// -----------------------------------------------------------------------------
module llink_tx_credit_fifo #(
    parameter int WIDTH  = 49,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CRED_W = 4
) (
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic              tx_online,
    input  logic              user_i_valid,
    input  logic [WIDTH-1:0]  txfifo_i_data,
    output logic              user_i_ready,
    output logic              tx_o_valid,
    output logic [WIDTH-1:0]  tx_o_data,
    input  logic              rx_credit_return,
    output logic              credit_overflow,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   status_level,
    output logic [CRED_W-1:0] status_credit
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   PTR_ONE    = 1;
    localparam logic [CRED_W-1:0] CRED_ONE   = 1;
    localparam logic [CRED_W-1:0] CRED_MAX   = '1;

    state_t            state_reg;
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic [CRED_W-1:0] credit_reg;
    logic [CRED_W-1:0] credit_next;
    logic              overflow_reg;
    logic              overflow_set;
    logic              tx_valid_reg;
    logic [WIDTH-1:0]  tx_data_reg;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means the write side has lapped the read side (full).
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Ready comes only from registered pointers, so a pop in the same cycle
    // as full does not raise ready until the next cycle.
    assign user_i_ready = !full && !rst_wr;
    assign push         = user_i_valid && user_i_ready;
    assign pop          = (state_reg == ST_ACTIVE) && !empty && (credit_reg != '0);

    // Credit update. Leaving ACTIVE (or sitting in IDLE) forces credit to 0,
    // so returns arriving while offline are discarded.
    always_comb begin
        credit_next  = credit_reg;
        overflow_set = 1'b0;
        if (state_reg == ST_IDLE || !tx_online) begin
            credit_next = '0;
        end else begin
            case ({pop, rx_credit_return})
                2'b10: credit_next = credit_reg - CRED_ONE;
                2'b01: begin
                    if (credit_reg == CRED_MAX) begin
                        overflow_set = 1'b1;
                    end else begin
                        credit_next = credit_reg + CRED_ONE;
                    end
                end
                default: credit_next = credit_reg;
            endcase
        end
    end

    // Storage array: written on push, read into the registered output stage
    // on pop. A word written at edge N is first readable in cycle N+1.
    always_ff @(posedge clk_wr) begin
        if (push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= txfifo_i_data;
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            credit_reg   <= '0;
            overflow_reg <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE:   if (tx_online)  state_reg <= ST_ACTIVE;
                ST_ACTIVE: if (!tx_online) state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                tx_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
            end
            credit_reg   <= credit_next;
            overflow_reg <= overflow_reg | overflow_set;
            tx_valid_reg <= pop;
        end
    end

    assign tx_o_valid      = tx_valid_reg;
    assign tx_o_data       = tx_data_reg;
    assign credit_overflow = overflow_reg;
    assign fifo_empty      = empty;

`ifdef LLINK_TX_STATUS_EN
    logic [ADDR_W:0] level_reg;

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            level_reg <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_reg <= level_reg + PTR_ONE;
                2'b01:   level_reg <= level_reg - PTR_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign status_level  = level_reg;
    assign status_credit = credit_reg;
`else
    assign status_level  = '0;
    assign status_credit = '0;
`endif

endmodule

// File: tb/tb_llink_tx_credit_fifo.sv
// -----------------------------------------------------------------------------
// tb_llink_tx_credit_fifo
//
// Directed bench for llink_tx_credit_fifo (WIDTH=49, DEPTH=8, CRED_W=4).
// Every pushbit is checked against a queue of words the bench has pushed,
// so ordering is verified throughout; pushbit counts prove credit gating.
// -----------------------------------------------------------------------------
module tb_llink_tx_credit_fifo;

    localparam int WIDTH  = 49;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CRED_W = 4;

    logic              clk_wr = 1'b0;
    logic              rst_wr = 1'b1;
    logic              tx_online = 1'b0;
    logic              user_i_valid = 1'b0;
    logic [WIDTH-1:0]  txfifo_i_data = '0;
    logic              user_i_ready;
    logic              tx_o_valid;
    logic [WIDTH-1:0]  tx_o_data;
    logic              rx_credit_return = 1'b0;
    logic              credit_overflow;
    logic              fifo_empty;
    logic [ADDR_W:0]   status_level;
    logic [CRED_W-1:0] status_credit;

    llink_tx_credit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .CRED_W(CRED_W)
    ) dut (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .tx_online       (tx_online),
        .user_i_valid    (user_i_valid),
        .txfifo_i_data   (txfifo_i_data),
        .user_i_ready    (user_i_ready),
        .tx_o_valid      (tx_o_valid),
        .tx_o_data       (tx_o_data),
        .rx_credit_return(rx_credit_return),
        .credit_overflow (credit_overflow),
        .fifo_empty      (fifo_empty),
        .status_level    (status_level),
        .status_credit   (status_credit)
    );

    always #5 clk_wr = ~clk_wr;

    int               checks = 0;
    int               errors = 0;
    int               n_tx   = 0;
    int               mark   = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int g, input int i);
        logic [WIDTH-1:0] w;
        w        = {17'h1A5A5, 32'h0};
        w[31:24] = g[7:0];
        w[7:0]   = i[7:0];
        return w;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_wr);
        #1;
        if (tx_o_valid) begin
            n_tx++;
            if (exp_q.size() == 0) begin
                chk("spurious_pushbit", tx_o_valid, 0);
            end else begin
                chk("pushbit_data", tx_o_data, exp_q.pop_front());
            end
            $display("pushbit #%0d data=%0h", n_tx, tx_o_data);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        chk("ready_before_push", user_i_ready, 1);
        user_i_valid  = 1'b1;
        txfifo_i_data = d;
        exp_q.push_back(d);
        tick();
        user_i_valid  = 1'b0;
    endtask

    task automatic pulse(input int n);
        rx_credit_return = 1'b1;
        repeat (n) tick();
        rx_credit_return = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle(2);
        chk("rst_ready_low",   user_i_ready,    0);
        chk("rst_tx_valid",    tx_o_valid,      0);
        chk("rst_fifo_empty",  fifo_empty,      1);
        chk("rst_tx_data",     tx_o_data,       0);
        chk("rst_overflow",    credit_overflow, 0);
        chk("rst_status_lvl",  status_level,    0);
        chk("rst_status_cred", status_credit,   0);
        rst_wr = 1'b0;
        #1;
        chk("ready_after_release", user_i_ready, 1);

        // ---------------- credit gate ----------------
        tx_online = 1'b1;
        idle(1);
        for (int i = 0; i < 3; i++) push_word(word(1, i));
        idle(3);
        chk("gate_no_pushbit", n_tx, 0);
        chk("gate_fifo_not_empty", fifo_empty, 0);
        pulse(2);
        idle(3);
        chk("gate_two_pushbits", n_tx, 2);
        chk("gate_valid_low", tx_o_valid, 0);
        chk("gate_data_held", tx_o_data, word(1, 1));
        chk("gate_third_held", fifo_empty, 0);

        // ---------------- reset mid-traffic ----------------
        pulse(2);                 // pops the third word, credit left at 1
        push_word(word(2, 0));    // will be discarded by reset
        rst_wr = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_o_valid, 0);
        chk("midrst_empty",    fifo_empty, 1);
        chk("midrst_ready",    user_i_ready, 0);
        exp_q.delete();
        tick();
        rst_wr = 1'b0;
        #1;
        chk("midrst_ready_after", user_i_ready, 1);
        tick();
        push_word(word(3, 0));
        idle(3);
        chk("midrst_credit_cleared", n_tx, 3);
        chk("midrst_word_held", fifo_empty, 0);
        pulse(1);
        idle(2);
        chk("midrst_word_out", n_tx, 4);
        chk("midrst_drained", fifo_empty, 1);

        // ---------------- full ----------------
        for (int i = 0; i < DEPTH; i++) push_word(word(4, i));
        chk("full_ready_low", user_i_ready, 0);
`ifdef LLINK_TX_STATUS_EN
        chk("full_status_level", status_level, DEPTH);
`endif
        user_i_valid  = 1'b1;
        txfifo_i_data = word(4, 8);
        tick();
        chk("full_9th_refused", user_i_ready, 0);
        chk("full_no_pushbit", n_tx, 4);
        rx_credit_return = 1'b1;
        tick();
        rx_credit_return = 1'b0;
        chk("full_pop_cycle_ready_low", user_i_ready, 0);
        tick();
        chk("full_ready_two_cycles_later", user_i_ready, 1);
        exp_q.push_back(word(4, 8));
        tick();
        user_i_valid = 1'b0;
        chk("full_again", user_i_ready, 0);

        // ---------------- simultaneous pop + return ----------------
        mark = n_tx;
        pulse(5);
        chk("stream_4_words", n_tx, mark + 4);
        chk("stream_valid_high", tx_o_valid, 1);
        tick();
        chk("stream_last_credit", n_tx, mark + 5);
        idle(2);
        chk("stream_credit_was_1", n_tx, mark + 5);
        pulse(3);
        idle(2);
        chk("stream_drained", n_tx, mark + 8);
        chk("stream_empty", fifo_empty, 1);

        // ---------------- credit overflow ----------------
        pulse(15);
        chk("ovf_not_yet", credit_overflow, 0);
        pulse(1);
        chk("ovf_set", credit_overflow, 1);
        idle(3);
        chk("ovf_sticky", credit_overflow, 1);
`ifdef LLINK_TX_STATUS_EN
        chk("ovf_status_credit", status_credit, 15);
`endif
        mark = n_tx;
        for (int i = 0; i < 8; i++) push_word(word(5, i));
        idle(3);
        chk("ovf_credit_first8", n_tx, mark + 8);
        for (int i = 0; i < 8; i++) push_word(word(6, i));
        idle(3);
        chk("ovf_credit_exactly15", n_tx, mark + 15);
        chk("ovf_last_word_held", fifo_empty, 0);

        // ---------------- offline ----------------
        pulse(6);                 // pops the held word, leaves credit at 5
        mark = n_tx;
        tx_online = 1'b0;
        for (int i = 0; i < 4; i++) push_word(word(7, i));
        idle(3);
        chk("offline_no_pops", n_tx, mark);
        chk("offline_fifo_kept", fifo_empty, 0);
        tx_online = 1'b1;
        idle(3);
        chk("offline_credit_cleared", n_tx, mark);
        pulse(4);
        idle(2);
        chk("offline_4_delivered", n_tx, mark + 4);
        chk("offline_empty", fifo_empty, 1);
        chk("offline_queue_drained", exp_q.size(), 0);
        chk("ovf_still_sticky", credit_overflow, 1);
`ifndef LLINK_TX_STATUS_EN
        chk("status_level_tied", status_level, 0);
        chk("status_credit_tied", status_credit, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
